// File: rtl/iot_event_serializer_if.sv
// Device-status in, serialised change events out; en=0 holds every event pending.
interface iot_event_serializer_if #(
    parameter int N_DEV = 8
);
    localparam int ID_W = $clog2(N_DEV);

    logic [N_DEV-1:0] dev_status;
    logic             en;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [ID_W:0]    pending_cnt;

    modport master (
        output dev_status, en,
        input  change, on_off, dev_id, pending_cnt
    );

    modport slave (
        input  dev_status, en,
        output change, on_off, dev_id, pending_cnt
    );
endinterface

// File: rtl/iot_event_serializer.sv
// Turns per-device status changes into one round-robin-arbitrated event per cycle, 2-cycle latency.
// No backpressure beyond en: while en=0 changes stay pending and are emitted once en returns high.
module iot_event_serializer #(
    parameter int N_DEV = 8
) (
    input  logic clk,
    input  logic rst,
    iot_event_serializer_if.slave bus
);
    localparam int ID_W = $clog2(N_DEV);

    logic [N_DEV-1:0] r_s;
    logic [N_DEV-1:0] r_rep;
    logic [ID_W-1:0]  r_ptr;
    logic             r_change;
    logic             r_on_off;
    logic [ID_W-1:0]  r_dev_id;
    logic [ID_W:0]    r_pending_cnt;

    logic [N_DEV-1:0] w_pend;
    logic             w_found;
    logic [ID_W-1:0]  w_g;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W:0]    w_cnt;

    // A device whose status flips back before being granted drops out of w_pend on its own.
    always_comb begin
        int idx;
        w_pend  = r_s ^ r_rep;
        w_found = 1'b0;
        w_g     = '0;
        idx     = 0;
        for (int k = 0; k < N_DEV; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_DEV) begin
                idx = idx - N_DEV;
            end
            if (!w_found && w_pend[ID_W'(idx)]) begin
                w_found = 1'b1;
                w_g     = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_DEV; i++) begin
            w_cnt = w_cnt + (ID_W+1)'(w_pend[i]);
        end
    end

    assign w_ptr_nxt = (w_g == ID_W'(N_DEV-1)) ? '0 : w_g + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s           <= '0;
            r_rep         <= '0;
            r_ptr         <= '0;
            r_change      <= 1'b0;
            r_on_off      <= 1'b0;
            r_dev_id      <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_s           <= bus.dev_status;
            r_pending_cnt <= w_cnt;
            if (bus.en && w_found) begin
                // Event carries the pre-update sample; a same-cycle change re-pends next cycle.
                r_change     <= 1'b1;
                r_dev_id     <= w_g;
                r_on_off     <= r_s[w_g];
                r_rep[w_g]   <= r_s[w_g];
                r_ptr        <= w_ptr_nxt;
            end else begin
                r_change <= 1'b0;
            end
        end
    end

    assign bus.change      = r_change;
    assign bus.on_off      = r_on_off;
    assign bus.dev_id      = r_dev_id;
    assign bus.pending_cnt = r_pending_cnt;
endmodule
